// File: rtl/rf_access_master.sv
// Single-outstanding host-to-register-file access master: one RF strobe per request, absorbs variable RF latency.
// Optional WAIT timeout (status 10) enabled by defining RF_ACCESS_TIMEOUT_EN.
module rf_access_master #(
  parameter int ADDR_HI     = 10,
  parameter int ADDR_LO     = 3,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_HI-ADDR_LO:0]   req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [1:0]                 rsp_status,
  output logic [ADDR_HI-ADDR_LO:0]   address,
  output logic                       read_en,
  output logic                       write_en,
  output logic [DATA_W-1:0]          write_data,
  input  logic [DATA_W-1:0]          read_data,
  input  logic                       invalid_address,
  input  logic                       access_complete
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_INVALID = 2'b01;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("rf_access_master: TIMEOUT_CYC must be within 2..255");
  end

  state_t state;
  logic   wr_lat;
`ifdef RF_ACCESS_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt;
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= IDLE;
      wr_lat     <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= ST_OK;
      address    <= '0;
      write_data <= '0;
      read_en    <= 1'b0;
      write_en   <= 1'b0;
`ifdef RF_ACCESS_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            address    <= req_addr;
            write_data <= req_wdata;
            wr_lat     <= req_write;
            read_en    <= ~req_write;
            write_en   <= req_write;
            req_ready  <= 1'b0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          read_en  <= 1'b0;
          write_en <= 1'b0;
`ifdef RF_ACCESS_TIMEOUT_EN
          cnt      <= '0;
`endif
          state    <= WAIT;
        end
        WAIT: begin
          // Completion always wins over a timeout landing in the same cycle.
          if (access_complete) begin
            rsp_status <= invalid_address ? ST_INVALID : ST_OK;
            rsp_rdata  <= (!invalid_address && !wr_lat) ? read_data : '0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
`ifdef RF_ACCESS_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            rsp_status <= ST_TIMEOUT;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_access_master.sv
// Directed bench for rf_access_master: cycle-exact RF responder with a response scoreboard.
module tb_rf_access_master;
  logic        clk = 1'b0;
  logic        res;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [7:0]  address;
  logic        read_en, write_en;
  logic [31:0] write_data, read_data;
  logic        invalid_address, access_complete;

  typedef struct packed { logic [1:0] st; logic [31:0] rd; } exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  rf_access_master #(.ADDR_HI(10), .ADDR_LO(3), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .address(address), .read_en(read_en), .write_en(write_en), .write_data(write_data),
    .read_data(read_data), .invalid_address(invalid_address), .access_complete(access_complete)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge after the DUT is idle again.
  task automatic access(input logic wr, input logic [7:0] a, input logic [31:0] wd, input int lat,
                        input logic [31:0] rd, input logic inv, input int bp);
    exp_t e;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    e.st = inv ? 2'b01 : 2'b00;
    e.rd = (wr || inv) ? 32'h0 : rd;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk("read_en_issue", read_en, !wr);
    chk("write_en_issue", write_en, wr);
    chk("address_issue", address, a);
    chk("write_data_issue", write_data, wd);
    chk("req_ready_busy", req_ready, 0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("strobes_wait", {read_en, write_en}, 2'b00);
      chk("address_wait", address, a);
      chk("write_data_wait", write_data, wd);
      chk("rsp_valid_wait", rsp_valid, 0);
      if (k == lat) begin access_complete = 1'b1; read_data = rd; invalid_address = inv; end
    end
    @(negedge clk);
    access_complete = 1'b0; invalid_address = 1'b0; read_data = $urandom;
    chk("rsp_valid_latency", rsp_valid, 1);
    e = sb.pop_front();
    chk("rsp_status", rsp_status, e.st);
    chk("rsp_rdata", rsp_rdata, e.rd);
    for (int k = 0; k < bp; k++) begin
      req_valid = 1'b1; req_addr = 8'hFF;
      if (k == 2) begin access_complete = 1'b1; invalid_address = 1'b1; read_data = 32'hBAD0BAD0; end
      @(negedge clk);
      access_complete = 1'b0; invalid_address = 1'b0;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_status", rsp_status, e.st);
      chk("bp_rsp_rdata", rsp_rdata, e.rd);
      chk("bp_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_done", rsp_valid, 0);
    chk("req_ready_done", req_ready, 1);
  endtask

  initial begin
    exp_t e;
    logic seen;
    res = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; read_data = '0; invalid_address = 1'b0; access_complete = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_strobes", {read_en, write_en, rsp_valid}, 3'b000);
    chk("rst_address", address, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_rsp", {rsp_status, rsp_rdata}, 34'h0);
    res = 1'b0;
    @(negedge clk);

    // Register write, RAM read, invalid address, backpressure with stray completion.
    access(1'b1, 8'h00, 32'hDEADBEEF, 1, 32'h0, 1'b0, 0);
    access(1'b0, 8'h85, 32'h0, 3, 32'h12345678, 1'b0, 0);
    access(1'b0, 8'h40, 32'h0, 1, 32'hCAFEF00D, 1'b1, 0);
    access(1'b0, 8'h21, 32'h5A5A5A5A, 1, 32'hA5A5_0001, 1'b0, 10);
    access(1'b1, 8'hC3, 32'h0F0F0F0F, 3, 32'hFFFF_FFFF, 1'b1, 0);

    // RF never completes.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h11;
    @(negedge clk);
    req_valid = 1'b0;
    chk("to_read_en", read_en, 1);
`ifdef RF_ACCESS_TIMEOUT_EN
    e.st = 2'b10; e.rd = 32'h0; sb.push_back(e);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      chk("to_rsp_valid_cycle", rsp_valid, (c == 17));
    end
    e = sb.pop_front();
    chk("to_status", rsp_status, e.st);
    chk("to_rdata", rsp_rdata, e.rd);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; access_complete = 1'b1; read_data = 32'h77777777;
    @(negedge clk);
    access_complete = 1'b0;
    @(negedge clk);
    chk("late_ac_rsp_valid", rsp_valid, 0);
    chk("late_ac_req_ready", req_ready, 1);
`else
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rsp_valid || req_ready) seen = 1'b1;
    end
    chk("no_timeout_100", seen, 0);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
`endif

    // Reset during ISSUE truncates the strobe immediately.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h3C; req_wdata = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_write_en", write_en, 1);
    res = 1'b1;
    #1;
    chk("rst_issue_write_en", write_en, 0);
    chk("rst_issue_req_ready", req_ready, 1);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);

    // Reset mid-WAIT of a RAM read; the late completion must produce nothing.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h85;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    res = 1'b1;
    #1;
    chk("rst_wait_strobes", {read_en, write_en, rsp_valid}, 3'b000);
    chk("rst_wait_req_ready", req_ready, 1);
    chk("rst_wait_address", address, 0);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    access_complete = 1'b1; read_data = 32'h12345678;
    @(negedge clk);
    access_complete = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready) seen = 1'b1;
    end
    chk("rst_late_completion", seen, 0);

    // Normal operation resumes after reset.
    access(1'b0, 8'h07, 32'h0, 1, 32'h0BADCAFE, 1'b0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
